img_hmap_gen: RTL

- Upstream neighbour of the image read controller. Builds and holds the per-output-row vertical map used for 1080-line scaling.
- The map has H_TOTAL entries, one per HDMI row, each {row_valid, org_h Q10.5}. It is rebuilt once per frame from a DDA accumulator.
- Serves 1-cycle-latency table reads to the read controller's H_RAM interface. Sits between the timing/config logic and the image read-request generator.

---
 rtl/img_hmap_pkg.sv | 24 ++
 rtl/img_hmap_ram.sv | 47 ++++
 rtl/img_hmap_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/img_hmap_pkg.sv
// Shared constants, types and the FSM state encoding for the vertical scaling map.
// No logic; sizes the table, the accumulator and the Q10.5 output.
// Optional feature macro used by the top: HMAP_CENTER_EN (half-step phase offset).
package img_hmap_pkg;

    localparam int H_TOTAL  = 1080;
    localparam int AW       = 11;
    localparam int ACC_FRAC = 16;
    localparam int OUT_FRAC = 5;
    localparam int ENTRY_W  = 16;
    localparam int ORG_W    = 15;
    localparam int ACC_W    = 10 + ACC_FRAC;
    localparam int STEP_W   = 1 + ACC_FRAC;
    localparam int SHIFT    = ACC_FRAC - OUT_FRAC;

    localparam logic [AW-1:0] LAST_ADDR = AW'(H_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/img_hmap_ram.sv
// Simple dual-port table: one write port, one registered read port.
// Latency 1 on reads; read data holds when no read is issued. No backpressure.
// A read and write to the same address in one cycle return the old contents.
// Ports: i_we/i_waddr/i_wdat write side; i_re/i_raddr read request; o_rdat read data.
module img_hmap_ram
    import img_hmap_pkg::*;
(
    input  logic               clk,
    input  logic               frst_n,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [ENTRY_W-1:0] i_wdat,
    input  logic               i_re,
    input  logic [AW-1:0]      i_raddr,
    output logic [ENTRY_W-1:0] o_rdat
);

    logic [ENTRY_W-1:0] mem [2**AW];
    logic [ENTRY_W-1:0] rdat_q;
    logic [ENTRY_W-1:0] rdat_d;

    // Array contents are not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdat;
        end
    end

    // The array read happens before the same-edge write lands, giving read-old.
    always_comb begin
        rdat_d = rdat_q;
        if (i_re) begin
            rdat_d = mem[i_raddr];
        end
    end

    always_ff @(posedge clk or negedge frst_n) begin
        if (!frst_n) begin
            rdat_q <= '0;
        end else begin
            rdat_q <= rdat_d;
        end
    end

    assign o_rdat = rdat_q;

endmodule

// File: rtl/img_hmap_gen.sv
// Builds the per-output-row vertical source map (valid + Q10.5 row) once per frame.
// Build takes H_TOTAL cycles from i_cfg_load; table reads have 1-cycle latency.
// No backpressure: reads are accepted every cycle, a new load restarts the build.
// Ports: i_cfg_* config sampled on i_cfg_load; o_busy/o_ready build status;
//        i_h_ram_re/i_h_ram_raddr read request; o_org_h/o_org_h_vld/o_h_ram_vld read data.
// Macro HMAP_CENTER_EN: accumulator starts at step/2 instead of 0.
module img_hmap_gen
    import img_hmap_pkg::*;
(
    input  logic              clk,
    input  logic              frst_n,
    input  logic              i_cfg_load,
    input  logic [10:0]       i_cfg_y_start,
    input  logic [10:0]       i_cfg_y_len,
    input  logic [16:0]       i_cfg_step,
    input  logic [9:0]        i_cfg_src_h,
    output logic              o_busy,
    output logic              o_ready,
    input  logic [AW-1:0]     i_h_ram_raddr,
    input  logic              i_h_ram_re,
    output logic [ORG_W-1:0]  o_org_h,
    output logic              o_org_h_vld,
    output logic              o_h_ram_vld
);

    state_e               state_q, state_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [10:0]          y_start_q, y_start_d;
    logic [10:0]          y_len_q, y_len_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [9:0]           src_h_q, src_h_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 h_ram_vld_q, h_ram_vld_d;

    logic [11:0]          wa12;
    logic [11:0]          ys12;
    logic [11:0]          rel12;
    logic                 row_in;
    logic [ORG_W-1:0]     org_raw;
    logic [ORG_W-1:0]     org_clamp;
    logic [9:0]           src_max;
    logic [ACC_W-1:0]     acc_init;
    logic                 wr_en;
    logic [ENTRY_W-1:0]   wr_dat;
    logic [ENTRY_W-1:0]   rd_dat;

`ifdef HMAP_CENTER_EN
    assign acc_init = ACC_W'(i_cfg_step >> 1);
`else
    assign acc_init = '0;
`endif

    // Window test in 12 bits so y_start + y_len beyond 2047 cannot wrap.
    always_comb begin
        wa12    = {1'b0, wr_addr_q};
        ys12    = {1'b0, y_start_q};
        rel12   = wa12 - ys12;
        row_in  = (wa12 >= ys12) && (rel12 < {1'b0, y_len_q});
        org_raw = acc_q[ACC_W-1:SHIFT];
        src_max = src_h_q - 10'd1;
        org_clamp = org_raw;
        if (org_raw[ORG_W-1:OUT_FRAC] > src_max) begin
            org_clamp = {src_max, {OUT_FRAC{1'b0}}};
        end
        wr_en  = (state_q == BUILD);
        wr_dat = row_in ? {1'b1, org_clamp} : '0;
    end

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        acc_d       = acc_q;
        y_start_d   = y_start_q;
        y_len_d     = y_len_q;
        step_d      = step_q;
        src_h_d     = src_h_q;
        h_ram_vld_d = i_h_ram_re;

        if (i_cfg_load) begin
            // Load is honoured in every state; a load mid-build restarts at row 0.
            y_start_d = i_cfg_y_start;
            y_len_d   = i_cfg_y_len;
            step_d    = i_cfg_step;
            src_h_d   = i_cfg_src_h;
            wr_addr_d = '0;
            acc_d     = acc_init;
            state_d   = BUILD;
        end else begin
            case (state_q)
                BUILD: begin
                    // Accumulator advances only after rows inside the image window.
                    if (row_in) begin
                        acc_d = acc_q + ACC_W'(step_q);
                    end
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d  = (state_d == BUILD);
        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge frst_n) begin
        if (!frst_n) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            acc_q       <= '0;
            y_start_q   <= '0;
            y_len_q     <= '0;
            step_q      <= '0;
            src_h_q     <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            h_ram_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            acc_q       <= acc_d;
            y_start_q   <= y_start_d;
            y_len_q     <= y_len_d;
            step_q      <= step_d;
            src_h_q     <= src_h_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            h_ram_vld_q <= h_ram_vld_d;
        end
    end

    img_hmap_ram u_ram (
        .clk     (clk),
        .frst_n  (frst_n),
        .i_we    (wr_en),
        .i_waddr (wr_addr_q),
        .i_wdat  (wr_dat),
        .i_re    (i_h_ram_re),
        .i_raddr (i_h_ram_raddr),
        .o_rdat  (rd_dat)
    );

    assign o_busy      = busy_q;
    assign o_ready     = ready_q;
    assign o_org_h     = rd_dat[ORG_W-1:0];
    assign o_org_h_vld = rd_dat[ENTRY_W-1];
    assign o_h_ram_vld = h_ram_vld_q;

endmodule
